hazard_stall_unit: RTL and testbench
====================================

// Module: hazard_stall_unit
// PURPOSE
//  ID-stage hazard detector; producer-side counterpart of the EX-stage operand bypass.
//  Detects hazards that bypassing cannot resolve: load-use, and branch compare in ID on an in-flight result.
//  Drives PC/IF_ID write enables, ID_EX bubble insert, IF_ID flush, and a pipeline-wide freeze on dmem busy.
// PARAMETERS
//  REG_W       5    register-index width
//  MAX_FREEZE  255  freeze cycles before freeze_timeout sets
//  CNT_W       32   perf-counter width (HAZARD_PERF_CNT_EN only)
// PORTS
//  clk                    in   1      rising-edge clock
//  rst_n                  in   1      synchronous reset, active-low
//  IF_ID_rs               in   REG_W  rs of instruction in ID
//  IF_ID_rt               in   REG_W  rt of instruction in ID
//  ID_uses_rt             in   1      ID instruction reads rt
//  ID_branch              in   1      ID instruction is beq/bne (compared in ID)
//  branch_taken           in   1      ID branch resolved taken
//  ID_EX_r                in   REG_W  destination register in EX
//  ID_EX_register_write   in   1      EX instruction writes a register
//  ID_EX_mem_read         in   1      EX instruction is a load
//  EX_MEM_r               in   REG_W  destination register in MEM
//  EX_MEM_mem_read        in   1      MEM instruction is a load
//  dmem_busy              in   1      data memory not ready this cycle
//  PC_write               out  1      PC update enable
//  IF_ID_write            out  1      IF_ID register enable
//  ID_EX_bubble           out  1      load NOP into ID_EX
//  IF_ID_flush            out  1      replace IF_ID with NOP
//  pipe_freeze            out  1      hold ID_EX, EX_MEM, MEM_WB
//  freeze_timeout         out  1      sticky watchdog flag
//  stall_cycles           out  CNT_W  perf: stall cycles
//  freeze_cycles          out  CNT_W  perf: freeze cycles
//  flush_count            out  CNT_W  perf: flushes
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=RUN, freeze_timeout=0, counters=0, freeze counter=0.
//  Outputs are Mealy on state and inputs, with zero-cycle latency. Idle values: PC_write=1, IF_ID_write=1, others 0.
//  match(r) = r!=0 & (r==IF_ID_rs | (ID_uses_rt & r==IF_ID_rt)).
//  LU   = ID_EX_mem_read & match(ID_EX_r).
//  BALU = ID_branch & ID_EX_register_write & !ID_EX_mem_read & match(ID_EX_r).
//  BLD  = ID_branch & ID_EX_mem_read & match(ID_EX_r).
//  BMEM = ID_branch & EX_MEM_mem_read & match(EX_MEM_r).
//  stall: PC_write=0, IF_ID_write=0, ID_EX_bubble=1.
//  States:
//   RUN:      dmem_busy -> FREEZE, save ret=RUN.
//             Else stall if LU|BALU|BMEM|BLD. BLD also goes to STALL2.
//             Else branch_taken -> IF_ID_flush=1.
//   STALL2:   dmem_busy -> FREEZE, save ret=STALL2. Else stall one cycle -> RUN.
//   FREEZE:   pipe_freeze=1, PC_write=0, IF_ID_write=0, bubble=0, flush=0.
//             Freeze counter increments, saturating at MAX_FREEZE. At MAX_FREEZE, freeze_timeout=1 (sticky until reset).
//             !dmem_busy -> return to ret, clear freeze counter.
//  Priority: dmem_busy > stall > flush. branch_taken is ignored in any stall or freeze cycle.
//  Register 0 never creates a hazard.
//  Reset asserted mid-FREEZE or mid-STALL2 returns to RUN next edge.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: stall_cycles, freeze_cycles and flush_count increment on stall, freeze and IF_ID_flush cycles respectively.
//   Counters wrap modulo 2^CNT_W.
//  HAZARD_PERF_CNT_EN undefined: no counter flops; the three ports are tied to 0.
// STRUCTURE
//  hazard_pkg: state encoding (RUN/STALL2/FREEZE), REG_ZERO constant, hazard-class localparams.
//  Sub-module hazard_perf_cnt: three enabled counters, instantiated only under HAZARD_PERF_CNT_EN.
// TESTING
//  Load-use: ID_EX_mem_read=1, ID_EX_r=8, IF_ID_rs=8
//   -> exactly 1 cycle of PC_write=0, ID_EX_bubble=1; no stall when IF_ID_rs=0, ID_EX_r=0.
//  Branch on load: ID_branch=1, ID_EX_mem_read=1, ID_EX_r=9=IF_ID_rt, ID_uses_rt=1
//   -> 2 stall cycles (RUN, STALL2), then RUN.
//  Taken branch: branch_taken=1, no hazard -> IF_ID_flush=1 for 1 cycle; with LU also asserted -> stall, no flush.
//  Freeze in STALL2: dmem_busy=1 for 3 cycles -> pipe_freeze=1 for 3 cycles, then one STALL2 stall, then RUN.
//  Watchdog: MAX_FREEZE=4, dmem_busy held 6 cycles -> freeze_timeout=1 and stays 1 after release until rst_n=0.
//  Perf (HAZARD_PERF_CNT_EN): after the above sequences, counters equal the exact stall, freeze and flush cycle counts.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared state encoding and hazard-class indices for the ID-stage hazard/stall unit
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL2 = 2'd1,
        ST_FREEZE = 2'd2
    } hz_state_t;

    localparam int REG_ZERO = 0;

    // Bit positions in the per-cycle hazard vector
    localparam int HZ_LU   = 0;
    localparam int HZ_BALU = 1;
    localparam int HZ_BLD  = 2;
    localparam int HZ_BMEM = 3;
    localparam int HZ_N    = 4;

endpackage

// File: rtl/hazard_perf_cnt.sv
// rtl/hazard_perf_cnt.sv - stall/freeze/flush event counters, free-running and wrapping
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_en,
    input  logic             freeze_en,
    input  logic             flush_en,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] freeze_cycles,
    output logic [CNT_W-1:0] flush_count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles  <= '0;
            freeze_cycles <= '0;
            flush_count   <= '0;
        end else begin
            if (stall_en)  stall_cycles  <= stall_cycles  + 1'b1;
            if (freeze_en) freeze_cycles <= freeze_cycles + 1'b1;
            if (flush_en)  flush_count   <= flush_count   + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - ID-stage load-use/branch hazard detector with dmem freeze and watchdog
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter int MAX_FREEZE = 255,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] IF_ID_rs,
    input  logic [REG_W-1:0] IF_ID_rt,
    input  logic             ID_uses_rt,
    input  logic             ID_branch,
    input  logic             branch_taken,
    input  logic [REG_W-1:0] ID_EX_r,
    input  logic             ID_EX_register_write,
    input  logic             ID_EX_mem_read,
    input  logic [REG_W-1:0] EX_MEM_r,
    input  logic             EX_MEM_mem_read,
    input  logic             dmem_busy,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             ID_EX_bubble,
    output logic             IF_ID_flush,
    output logic             pipe_freeze,
    output logic             freeze_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] freeze_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int FC_W = $clog2(MAX_FREEZE + 1);
    localparam logic [REG_W-1:0] ZERO_R = REG_W'(REG_ZERO);

    hz_state_t       state, state_next;
    hz_state_t       ret, ret_next;
    logic [FC_W-1:0] fcnt;
    logic            ex_match, mem_match;
    logic [HZ_N-1:0] hz;

    assign ex_match  = (ID_EX_r != ZERO_R) &&
                       ((ID_EX_r == IF_ID_rs) || (ID_uses_rt && (ID_EX_r == IF_ID_rt)));
    assign mem_match = (EX_MEM_r != ZERO_R) &&
                       ((EX_MEM_r == IF_ID_rs) || (ID_uses_rt && (EX_MEM_r == IF_ID_rt)));

    // An ALU result in EX is forwardable to EX but not to a branch compared in ID
    assign hz[HZ_LU]   = ID_EX_mem_read && ex_match;
    assign hz[HZ_BALU] = ID_branch && ID_EX_register_write && !ID_EX_mem_read && ex_match;
    assign hz[HZ_BLD]  = ID_branch && ID_EX_mem_read && ex_match;
    assign hz[HZ_BMEM] = ID_branch && EX_MEM_mem_read && mem_match;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RUN;
            ret   <= ST_RUN;
        end else begin
            state <= state_next;
            ret   <= ret_next;
        end
    end

    always_comb begin
        state_next   = state;
        ret_next     = ret;
        PC_write     = 1'b1;
        IF_ID_write  = 1'b1;
        ID_EX_bubble = 1'b0;
        IF_ID_flush  = 1'b0;
        pipe_freeze  = 1'b0;
        case (state)
            ST_RUN: begin
                if (dmem_busy) begin
                    state_next = ST_FREEZE;
                    ret_next   = ST_RUN;
                end else if (|hz) begin
                    PC_write     = 1'b0;
                    IF_ID_write  = 1'b0;
                    ID_EX_bubble = 1'b1;
                    if (hz[HZ_BLD]) state_next = ST_STALL2;
                end else if (branch_taken) begin
                    IF_ID_flush = 1'b1;
                end
            end
            ST_STALL2: begin
                if (dmem_busy) begin
                    state_next = ST_FREEZE;
                    ret_next   = ST_STALL2;
                end else begin
                    PC_write     = 1'b0;
                    IF_ID_write  = 1'b0;
                    ID_EX_bubble = 1'b1;
                    state_next   = ST_RUN;
                end
            end
            ST_FREEZE: begin
                pipe_freeze = 1'b1;
                PC_write    = 1'b0;
                IF_ID_write = 1'b0;
                if (!dmem_busy) state_next = ret;
            end
            default: state_next = ST_RUN;
        endcase
    end

    // Freeze watchdog: counter saturates, flag stays set until reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fcnt           <= '0;
            freeze_timeout <= 1'b0;
        end else if (state == ST_FREEZE) begin
            if (!dmem_busy) begin
                fcnt <= '0;
            end else begin
                if (fcnt != FC_W'(MAX_FREEZE)) fcnt <= fcnt + 1'b1;
                if (fcnt >= FC_W'(MAX_FREEZE - 1)) freeze_timeout <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_cnt #(
        .CNT_W(CNT_W)
    ) u_perf_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_en     (ID_EX_bubble),
        .freeze_en    (pipe_freeze),
        .flush_en     (IF_ID_flush),
        .stall_cycles (stall_cycles),
        .freeze_cycles(freeze_cycles),
        .flush_count  (flush_count)
    );
`else
    assign stall_cycles  = '0;
    assign freeze_cycles = '0;
    assign flush_count   = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - scoreboard bench for hazard_stall_unit with hand-derived expected vectors
module tb_hazard_stall_unit;

    localparam int CNT_W = 32;
    // {PC_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, pipe_freeze}
    localparam logic [4:0] IDLE  = 5'b11000;
    localparam logic [4:0] STALL = 5'b00100;
    localparam logic [4:0] FLUSH = 5'b11010;
    localparam logic [4:0] FRZ   = 5'b00001;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] IF_ID_rs, IF_ID_rt, ID_EX_r, EX_MEM_r;
    logic ID_uses_rt, ID_branch, branch_taken, ID_EX_register_write;
    logic ID_EX_mem_read, EX_MEM_mem_read, dmem_busy;
    logic PC_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, pipe_freeze, freeze_timeout;
    logic [CNT_W-1:0] stall_cycles, freeze_cycles, flush_count;

    typedef struct {
        int         id;
        logic [4:0] e;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    int vec_id = 0;
    int exp_stall = 0;
    int exp_freeze = 0;
    int exp_flush = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(
        .REG_W(5),
        .MAX_FREEZE(4),
        .CNT_W(CNT_W)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .IF_ID_rs            (IF_ID_rs),
        .IF_ID_rt            (IF_ID_rt),
        .ID_uses_rt          (ID_uses_rt),
        .ID_branch           (ID_branch),
        .branch_taken        (branch_taken),
        .ID_EX_r             (ID_EX_r),
        .ID_EX_register_write(ID_EX_register_write),
        .ID_EX_mem_read      (ID_EX_mem_read),
        .EX_MEM_r            (EX_MEM_r),
        .EX_MEM_mem_read     (EX_MEM_mem_read),
        .dmem_busy           (dmem_busy),
        .PC_write            (PC_write),
        .IF_ID_write         (IF_ID_write),
        .ID_EX_bubble        (ID_EX_bubble),
        .IF_ID_flush         (IF_ID_flush),
        .pipe_freeze         (pipe_freeze),
        .freeze_timeout      (freeze_timeout),
        .stall_cycles        (stall_cycles),
        .freeze_cycles       (freeze_cycles),
        .flush_count         (flush_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                         input logic br, input logic tk, input logic [4:0] exr,
                         input logic exwr, input logic exmr, input logic [4:0] memr,
                         input logic memmr, input logic busy, input logic [4:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        IF_ID_rs = rs;  IF_ID_rt = rt;  ID_uses_rt = urt;
        ID_branch = br; branch_taken = tk;
        ID_EX_r = exr;  ID_EX_register_write = exwr; ID_EX_mem_read = exmr;
        EX_MEM_r = memr; EX_MEM_mem_read = memmr; dmem_busy = busy;
        x.id = vec_id;
        x.e  = e;
        vec_id++;
        sb.push_back(x);
        if (e[2]) exp_stall++;
        if (e[1]) exp_flush++;
        if (e[0]) exp_freeze++;
    endtask

    task automatic idle(input logic busy, input logic [4:0] e);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, busy, e);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t x;
            x = sb.pop_front();
            check($sformatf("vec%0d", x.id),
                  {27'b0, PC_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, pipe_freeze},
                  {27'b0, x.e});
        end
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout got=running want=finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        IF_ID_rs = 0; IF_ID_rt = 0; ID_uses_rt = 0; ID_branch = 0; branch_taken = 0;
        ID_EX_r = 0; ID_EX_register_write = 0; ID_EX_mem_read = 0;
        EX_MEM_r = 0; EX_MEM_mem_read = 0; dmem_busy = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_outs", {27'b0, PC_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, pipe_freeze},
              {27'b0, IDLE});
        check("rst_timeout", freeze_timeout, 0);
        check("rst_stall_cnt", stall_cycles, 0);
        check("rst_freeze_cnt", freeze_cycles, 0);
        check("rst_flush_cnt", flush_count, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // load-use on rs, register 0, load-use on rt, rt unused
        drive(8, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0, STALL);
        drive(8, 0, 0, 0, 0, 0, 0, 0, 8, 1, 0, IDLE);
        drive(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, IDLE);
        drive(0, 5, 1, 0, 0, 5, 1, 1, 0, 0, 0, STALL);
        drive(0, 5, 0, 0, 0, 5, 1, 1, 0, 0, 0, IDLE);
        // branch on load: two stalls, taken ignored in STALL2, then flush from RUN
        drive(0, 9, 1, 1, 0, 9, 1, 1, 0, 0, 0, STALL);
        drive(0, 9, 1, 1, 1, 0, 0, 0, 9, 1, 0, STALL);
        drive(0, 9, 1, 1, 1, 0, 0, 0, 0, 0, 0, FLUSH);
        idle(0, IDLE);
        // branch on ALU result in EX; non-branch ALU dependency is bypassed
        drive(3, 0, 0, 1, 0, 3, 1, 0, 0, 0, 0, STALL);
        drive(3, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, IDLE);
        // branch on load in MEM; ALU result in MEM is no hazard
        drive(4, 0, 0, 1, 0, 0, 0, 0, 4, 1, 0, STALL);
        drive(4, 0, 0, 1, 0, 0, 0, 0, 4, 0, 0, IDLE);
        // taken branch together with load-use: stall wins
        drive(7, 0, 0, 0, 1, 7, 1, 1, 0, 0, 0, STALL);
        // freeze entered from STALL2, returns to STALL2
        drive(0, 9, 1, 1, 0, 9, 1, 1, 0, 0, 0, STALL);
        drive(0, 9, 1, 1, 0, 0, 0, 0, 9, 1, 1, IDLE);
        drive(0, 9, 1, 1, 1, 0, 0, 0, 9, 1, 1, FRZ);
        drive(0, 9, 1, 1, 1, 0, 0, 0, 9, 1, 1, FRZ);
        drive(0, 9, 1, 1, 0, 0, 0, 0, 9, 1, 0, FRZ);
        drive(0, 9, 1, 1, 0, 0, 0, 0, 9, 1, 0, STALL);
        idle(0, IDLE);
        // dmem_busy outranks load-use
        drive(8, 0, 0, 0, 0, 8, 1, 1, 0, 0, 1, IDLE);
        drive(8, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0, FRZ);
        drive(8, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0, STALL);
        // watchdog just below threshold
        idle(1, IDLE);
        repeat (3) idle(1, FRZ);
        idle(0, FRZ);
        idle(0, IDLE);
        @(negedge clk);
        check("wd_below", freeze_timeout, 0);
        // watchdog reaches threshold and stays set
        idle(1, IDLE);
        repeat (5) idle(1, FRZ);
        idle(0, FRZ);
        idle(0, IDLE);
        @(negedge clk);
        check("wd_set", freeze_timeout, 1);
        idle(0, IDLE);
        idle(0, IDLE);
        @(negedge clk);
        check("wd_sticky", freeze_timeout, 1);
`ifdef HAZARD_PERF_CNT_EN
        check("perf_stall", stall_cycles, exp_stall);
        check("perf_freeze", freeze_cycles, exp_freeze);
        check("perf_flush", flush_count, exp_flush);
`else
        check("perf_stall_off", stall_cycles, 0);
        check("perf_freeze_off", freeze_cycles, 0);
        check("perf_flush_off", flush_count, 0);
`endif
        // reset mid-FREEZE
        idle(1, IDLE);
        idle(1, FRZ);
        rst_n = 1'b0;
        idle(0, IDLE);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_wd_clear", freeze_timeout, 0);
        // reset mid-STALL2 with busy: without reset this would freeze
        drive(0, 9, 1, 1, 0, 9, 1, 1, 0, 0, 0, STALL);
        idle(1, IDLE);
        rst_n = 1'b0;
        idle(0, IDLE);
        rst_n = 1'b1;
        idle(0, IDLE);
        @(negedge clk);
        check("rst2_stall_cnt", stall_cycles, 0);
        check("rst2_freeze_cnt", freeze_cycles, 0);
        check("rst2_flush_cnt", flush_count, 0);
        @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
